// File: rtl/jk_pkg.sv
// Shared types and constants for the JK flip-flop bank drive controller.
// Excitation codes are packed as {j, k}.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: picks the {j, k} pair that moves a JK flop from q to t.
// Purely combinational; the controller registers the result.
module jk_excite
    import jk_pkg::*;
(
    input  logic q,
    input  logic t,
    input  logic toggle_en,
    output logic j,
    output logic k
);

    logic [1:0] code;

    always_comb begin
        code = JK_HOLD;
        if (q != t) begin
            if (toggle_en) begin
                code = JK_TOG;
            end else if (t) begin
                code = JK_SET;
            end else begin
                code = JK_RST;
            end
        end
    end

    assign {j, k} = code;

endmodule

// File: rtl/jk_drive_ctrl.sv
// Drives an external bank of JK flip-flops to a requested word, then checks
// the Q/Q_bar feedback and records per-bit failures and an error history.
module jk_drive_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit TOGGLE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    input  logic [WIDTH-1:0] q_bar_fb,
    output logic             done,
    output logic [WIDTH-1:0] err_mask,
    output logic             err,
    input  logic             err_clr,
    output logic [7:0]       err_cnt
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] target_reg, target_next;
    logic [WIDTH-1:0] j_reg, j_next;
    logic [WIDTH-1:0] k_reg, k_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] err_mask_reg, err_mask_next;
    logic             err_reg, err_next;
    logic [7:0]       err_cnt_reg, err_cnt_next;
    logic             tgt_ready_reg, tgt_ready_next;

    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic [WIDTH-1:0] check_err;
    logic             err_set;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_excite
            jk_excite u_excite (
                .q         (q_fb[gi]),
                .t         (tgt_data[gi]),
                .toggle_en (TOGGLE_EN),
                .j         (exc_j[gi]),
                .k         (exc_k[gi])
            );
        end
    endgenerate

    // A bit fails if it missed the target or its complementary outputs agree.
    assign check_err = (q_fb ^ target_reg) | ~(q_bar_fb ^ q_fb);

    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        j_next         = '0;
        k_next         = '0;
        done_next      = 1'b0;
        err_mask_next  = err_mask_reg;
        err_cnt_next   = err_cnt_reg;
        tgt_ready_next = 1'b0;
        err_set        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tgt_ready_next = 1'b1;
                if (tgt_valid && tgt_ready_reg) begin
                    target_next    = tgt_data;
                    j_next         = exc_j;
                    k_next         = exc_k;
                    tgt_ready_next = 1'b0;
                    state_next     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                err_mask_next  = check_err;
                done_next      = 1'b1;
                tgt_ready_next = 1'b1;
                state_next     = ST_IDLE;
                if (|check_err) begin
                    err_set = 1'b1;
                    if (err_cnt_reg != ERR_CNT_MAX) begin
                        err_cnt_next = err_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                tgt_ready_next = 1'b1;
                state_next     = ST_IDLE;
            end
        endcase

        // A new failure wins over a same-cycle clear.
        err_next = err_set | (err_reg & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            target_reg    <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            done_reg      <= 1'b0;
            err_mask_reg  <= '0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
            tgt_ready_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            target_reg    <= target_next;
            j_reg         <= j_next;
            k_reg         <= k_next;
            done_reg      <= done_next;
            err_mask_reg  <= err_mask_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
            tgt_ready_reg <= tgt_ready_next;
        end
    end

    assign tgt_ready = tgt_ready_reg;
    assign j         = j_reg;
    assign k         = k_reg;
    assign done      = done_reg;
    assign err_mask  = err_mask_reg;
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Scoreboard bench: one toggle-mode and one set/reset-mode controller share stimulus,
// each driving its own behavioural JK bank with injectable feedback faults.
module tb_jk_drive_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] j0, k0, j1, k1;
    } drv_exp_t;

    typedef struct {
        logic [W-1:0] mask;
        logic         err;
        logic [7:0]   cnt;
    } chk_exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data = '0;
    logic         err_clr = 1'b0;

    logic         tgt_ready0, tgt_ready1, done0, done1, err0, err1;
    logic [W-1:0] j0, k0, j1, k1, mask0, mask1;
    logic [W-1:0] q0, qb0, q1, qb1;
    logic [7:0]   cnt0, cnt1;

    logic [W-1:0] bank0 = '0;
    logic [W-1:0] bank1 = '0;
    logic         stuck_en = 1'b0;
    logic [W-1:0] stuck_val = '0;
    logic [W-1:0] qbar_bad = '0;

    drv_exp_t drv_q[$];
    chk_exp_t chk_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    logic     model_err = 1'b0;
    int       model_cnt = 0;

    always #5 clk = ~clk;

    jk_drive_ctrl #(.WIDTH(W), .TOGGLE_EN(1'b1)) u_tog (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(tgt_ready0), .j(j0), .k(k0), .q_fb(q0), .q_bar_fb(qb0),
        .done(done0), .err_mask(mask0), .err(err0), .err_clr(err_clr), .err_cnt(cnt0)
    );

    jk_drive_ctrl #(.WIDTH(W), .TOGGLE_EN(1'b0)) u_sr (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(tgt_ready1), .j(j1), .k(k1), .q_fb(q1), .q_bar_fb(qb1),
        .done(done1), .err_mask(mask1), .err(err1), .err_clr(err_clr), .err_cnt(cnt1)
    );

    // JK characteristic equation: Q+ = J & ~Q | ~K & Q
    function automatic logic [W-1:0] jk_step(input logic [W-1:0] q, input logic [W-1:0] jj,
                                             input logic [W-1:0] kk);
        return (jj & ~q) | (~kk & q);
    endfunction

    always @(posedge clk) begin
        if (!$isunknown({j0, k0})) bank0 <= jk_step(bank0, j0, k0);
        if (!$isunknown({j1, k1})) bank1 <= jk_step(bank1, j1, k1);
    end

    assign q0  = stuck_en ? stuck_val : bank0;
    assign q1  = stuck_en ? stuck_val : bank1;
    assign qb0 = ~q0 ^ qbar_bad;
    assign qb1 = ~q1 ^ qbar_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Required drive pattern from the visible Q: toggle mode flips differing bits,
    // set/reset mode sets bits that must rise and resets bits that must fall.
    function automatic void push_drive(input logic [W-1:0] t);
        drv_exp_t d;
        d.j0 = q0 ^ t;
        d.k0 = q0 ^ t;
        d.j1 = t & ~q1;
        d.k1 = q1 & ~t;
        drv_q.push_back(d);
    endfunction

    function automatic void push_check(input logic [W-1:0] t, input logic clr);
        chk_exp_t c;
        logic [W-1:0] seen_after;
        seen_after = stuck_en ? stuck_val : t;
        c.mask = (seen_after ^ t) | qbar_bad;
        if (c.mask != '0) begin
            model_err = 1'b1;
            if (model_cnt < 255) model_cnt++;
        end else if (clr) begin
            model_err = 1'b0;
        end
        c.err = model_err;
        c.cnt = 8'(model_cnt);
        chk_q.push_back(c);
    endfunction

    // Monitor: drive cycle follows tgt_ready falling; check cycle has j=k=0; done pops a result.
    logic prev_ready = 1'b0;
    logic done_prev = 1'b0;
    bit   drive_seen = 1'b0;

    always @(negedge clk) begin
        drv_exp_t d;
        chk_exp_t c;
        if (drive_seen) begin
            check("check_cycle_j0", 32'(j0), 32'(0));
            check("check_cycle_k0", 32'(k0), 32'(0));
            check("check_cycle_j1", 32'(j1), 32'(0));
            check("check_cycle_k1", 32'(k1), 32'(0));
            drive_seen = 1'b0;
        end
        if (prev_ready === 1'b1 && tgt_ready0 === 1'b0) begin
            check("ready_match", 32'(tgt_ready1), 32'(0));
            if (drv_q.size() == 0) begin
                check("unexpected_drive", 32'(1), 32'(0));
            end else begin
                d = drv_q.pop_front();
                check("drive_j_tog", 32'(j0), 32'(d.j0));
                check("drive_k_tog", 32'(k0), 32'(d.k0));
                check("drive_j_sr", 32'(j1), 32'(d.j1));
                check("drive_k_sr", 32'(k1), 32'(d.k1));
            end
            drive_seen = 1'b1;
        end
        if (done0 === 1'b1 || done1 === 1'b1) begin
            check("done_both", 32'({done0, done1}), 32'(2'b11));
            check("done_one_cycle", 32'(done_prev), 32'(0));
            if (chk_q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                c = chk_q.pop_front();
                check("err_mask_tog", 32'(mask0), 32'(c.mask));
                check("err_mask_sr", 32'(mask1), 32'(c.mask));
                check("err_tog", 32'(err0), 32'(c.err));
                check("err_sr", 32'(err1), 32'(c.err));
                check("err_cnt_tog", 32'(cnt0), 32'(c.cnt));
                check("err_cnt_sr", 32'(cnt1), 32'(c.cnt));
            end
        end
        done_prev  = done0;
        prev_ready = tgt_ready0;
    end

    task automatic check_idle_reset_state(input string tag);
        check({tag, "_ready"}, 32'({tgt_ready0, tgt_ready1}), 32'(2'b11));
        check({tag, "_jk"}, 32'({j0, k0, j1, k1}), 32'(0));
        check({tag, "_done"}, 32'({done0, done1}), 32'(0));
        check({tag, "_err"}, 32'({err0, err1}), 32'(0));
        check({tag, "_cnt"}, 32'({cnt0, cnt1}), 32'(0));
    endtask

    task automatic do_xfer(input logic [W-1:0] t, input logic clr, input bit abort);
        int waited = 0;
        @(negedge clk);
        while (tgt_ready0 !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (tgt_ready0 !== 1'b1) begin
            check("ready_timeout", 32'(tgt_ready0), 32'(1));
            return;
        end
        tgt_valid = 1'b1;
        tgt_data  = t;
        push_drive(t);
        if (!abort) push_check(t, clr);
        $display("xfer tgt=%b q_tog=%b q_sr=%b stuck=%0d qbar_bad=%b clr=%0d abort=%0d",
                 t, q0, q1, stuck_en, qbar_bad, clr, abort);
        @(negedge clk);
        tgt_valid = 1'b0;
        tgt_data  = W'($urandom);
        if (abort) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            model_err = 1'b0;
            model_cnt = 0;
            check_idle_reset_state("abort");
            repeat (3) @(negedge clk);
            return;
        end
        @(negedge clk);
        err_clr = clr;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic idle_clear();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_err = 1'b0;
        $display("err_clr pulse in idle");
        check("idle_clear_err", 32'({err0, err1}), 32'(0));
        check("idle_clear_cnt_kept", 32'(cnt0), 32'(model_cnt));
    endtask

    initial begin
        int last;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_reset_state("reset");
        check("reset_mask", 32'({mask0, mask1}), 32'(0));

        do_xfer(4'b1010, 1'b0, 1'b0);
        do_xfer(4'b1100, 1'b0, 1'b0);
        do_xfer(4'b0101, 1'b0, 1'b0);
        do_xfer(4'b0110, 1'b0, 1'b0);
        do_xfer(4'b0110, 1'b0, 1'b0);

        stuck_en  = 1'b1;
        stuck_val = 4'b0000;
        do_xfer(4'b0011, 1'b0, 1'b0);
        do_xfer(4'b0011, 1'b1, 1'b0);
        stuck_en = 1'b0;
        idle_clear();

        qbar_bad = 4'b0100;
        do_xfer(4'b1001, 1'b0, 1'b0);
        qbar_bad = '0;
        do_xfer(4'b1111, 1'b1, 1'b0);

        do_xfer(4'b0001, 1'b0, 1'b1);
        do_xfer(4'b1000, 1'b0, 1'b0);

        // Backpressure: valid held high, data changing every cycle.
        @(negedge clk);
        tgt_valid = 1'b1;
        last = -1;
        for (int c = 0; c < 12; c++) begin
            tgt_data = W'($urandom);
            if (tgt_ready0 === 1'b1) begin
                push_drive(tgt_data);
                push_check(tgt_data, 1'b0);
                $display("backpressure accept cycle=%0d tgt=%b", c, tgt_data);
                if (last >= 0) check("accept_spacing", 32'(c - last), 32'(3));
                last = c;
            end
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        repeat (4) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            stuck_en  = ($urandom_range(0, 5) == 0);
            stuck_val = W'($urandom);
            qbar_bad  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(1, 15)) : '0;
            do_xfer(W'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 9) == 0) begin
                stuck_en = 1'b0;
                qbar_bad = '0;
                idle_clear();
            end
        end
        stuck_en = 1'b0;
        qbar_bad = '0;

        repeat (5) @(negedge clk);
        check("drive_queue_drained", 32'(drv_q.size()), 32'(0));
        check("check_queue_drained", 32'(chk_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
